// File: rtl/vga_fb_sequencer.sv
// Write-port sequencer for the 80x60 framebuffer: CPU pixel writes take priority over a rectangle-fill engine.
// Define VGA_FB_SEQ_AUTOCLEAR_EN to clear the whole framebuffer to 8'h00 after every reset.
module vga_fb_sequencer #(
  parameter int H_PIX = 80,
  parameter int V_PIX = 60
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_we_i,
  input  logic [12:0] cpu_wa_i,
  input  logic [7:0]  cpu_wd_i,
  input  logic        fill_start_i,
  input  logic [6:0]  fill_x0_i,
  input  logic [6:0]  fill_x1_i,
  input  logic [5:0]  fill_y0_i,
  input  logic [5:0]  fill_y1_i,
  input  logic [7:0]  fill_color_i,
  input  logic        fill_abort_i,
  output logic [12:0] fb_wa_o,
  output logic [7:0]  fb_wd_o,
  output logic        fb_we_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef VGA_FB_SEQ_AUTOCLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CLEAR} state_e;
  localparam state_e     RST_STATE = S_CLEAR;
  localparam logic [6:0] X1_RST    = 7'(H_PIX - 1);
  localparam logic [5:0] Y1_RST    = 6'(V_PIX - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL} state_e;
  localparam state_e     RST_STATE = S_IDLE;
  localparam logic [6:0] X1_RST    = 7'd0;
  localparam logic [5:0] Y1_RST    = 6'd0;
`endif

  localparam logic [7:0] H_LIM = 8'(H_PIX);
  localparam logic [6:0] V_LIM = 7'(V_PIX);

  state_e      state_q, state_d;
  logic [6:0]  x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
  logic [5:0]  y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
  logic [7:0]  color_q, color_d;
  logic [12:0] shadow_q, shadow_d;
  logic [12:0] fb_wa_q, fb_wa_d;
  logic [7:0]  fb_wd_q, fb_wd_d;
  logic        fb_we_q, fb_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic        last_px;
  logic        row_end;
  logic [6:0]  cx_nxt;
  logic [5:0]  cy_nxt;

  assign req_bad = (fill_x0_i > fill_x1_i) || (fill_y0_i > fill_y1_i) ||
                   ({1'b0, fill_x1_i} >= H_LIM) || ({1'b0, fill_y1_i} >= V_LIM);

  assign row_end = (cx_q == x1_q);
  assign last_px = row_end && (cy_q == y1_q);
  assign cx_nxt  = row_end ? x0_q : cx_q + 7'd1;
  assign cy_nxt  = row_end ? cy_q + 6'd1 : cy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= RST_STATE;
      x0_q     <= 7'd0;
      x1_q     <= X1_RST;
      y0_q     <= 6'd0;
      y1_q     <= Y1_RST;
      cx_q     <= 7'd0;
      cy_q     <= 6'd0;
      color_q  <= 8'd0;
      shadow_q <= 13'd0;
      fb_wa_q  <= 13'd0;
      fb_wd_q  <= 8'd0;
      fb_we_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      color_q  <= color_d;
      shadow_q <= shadow_d;
      fb_wa_q  <= fb_wa_d;
      fb_wd_q  <= fb_wd_d;
      fb_we_q  <= fb_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    color_d  = color_q;
    shadow_d = shadow_q;
    fb_wa_d  = fb_wa_q;
    fb_wd_d  = fb_wd_q;
    fb_we_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Park the address on the last CPU pixel so readback sees it.
        fb_wa_d = shadow_q;
        if (fill_start_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            x0_d    = fill_x0_i;
            x1_d    = fill_x1_i;
            y0_d    = fill_y0_i;
            y1_d    = fill_y1_i;
            color_d = fill_color_i;
            cx_d    = fill_x0_i;
            cy_d    = fill_y0_i;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (fill_abort_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!cpu_we_i) begin
          fb_we_d = 1'b1;
          fb_wa_d = {cy_q, cx_q};
          fb_wd_d = color_q;
          cx_d    = cx_nxt;
          cy_d    = cy_nxt;
          if (last_px) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef VGA_FB_SEQ_AUTOCLEAR_EN
      S_CLEAR: begin
        if (!cpu_we_i) begin
          fb_we_d = 1'b1;
          fb_wa_d = {cy_q, cx_q};
          fb_wd_d = 8'h00;
          cx_d    = cx_nxt;
          cy_d    = cy_nxt;
          if (last_px) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // CPU write overrides whatever the engine chose; its cursor already held above.
    if (cpu_we_i) begin
      fb_we_d  = 1'b1;
      fb_wa_d  = cpu_wa_i;
      fb_wd_d  = cpu_wd_i;
      shadow_d = cpu_wa_i;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign fb_wa_o = fb_wa_q;
  assign fb_wd_o = fb_wd_q;
  assign fb_we_o = fb_we_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_vga_fb_sequencer.sv
// Directed bench for vga_fb_sequencer: CPU path, fills, contention, rejects, abort, reset, optional autoclear.
module tb_vga_fb_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [12:0] cpu_wa;
  logic [7:0]  cpu_wd;
  logic        fill_start;
  logic [6:0]  fill_x0, fill_x1;
  logic [5:0]  fill_y0, fill_y1;
  logic [7:0]  fill_color;
  logic        fill_abort;
  logic [12:0] fb_wa;
  logic [7:0]  fb_wd;
  logic        fb_we, busy, done, err;

  int passed = 0;
  int total  = 0;

  vga_fb_sequencer #(.H_PIX(80), .V_PIX(60)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_we_i(cpu_we), .cpu_wa_i(cpu_wa), .cpu_wd_i(cpu_wd),
    .fill_start_i(fill_start), .fill_x0_i(fill_x0), .fill_x1_i(fill_x1),
    .fill_y0_i(fill_y0), .fill_y1_i(fill_y1), .fill_color_i(fill_color),
    .fill_abort_i(fill_abort),
    .fb_wa_o(fb_wa), .fb_wd_o(fb_wd), .fb_we_o(fb_we),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_fill(input logic [6:0] x0, input logic [6:0] x1,
                            input logic [5:0] y0, input logic [5:0] y1, input logic [7:0] c);
    fill_start = 1'b1;
    fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
  endtask

`ifdef VGA_FB_SEQ_AUTOCLEAR_EN
  task automatic run_clear();
    int writes = 0, bad_data = 0, bad_addr = 0, dones = 0;
    tick();
    chk("clear_busy_start", busy, 1'b1);
    for (int i = 0; i < 4900; i++) begin
      if (fb_we) begin
        writes++;
        if (fb_wd !== 8'h00) bad_data++;
        if (fb_wa[6:0] >= 7'd80 || fb_wa[12:7] >= 6'd60) bad_addr++;
      end
      if (done) dones++;
      tick();
    end
    chk("clear_writes", writes, 4800);
    chk("clear_bad_data", bad_data, 0);
    chk("clear_bad_addr", bad_addr, 0);
    chk("clear_no_done", dones, 0);
    chk("clear_busy_end", busy, 1'b0);
  endtask
`endif

  initial begin
    int cnt_we, cnt_done;
    rst_n = 1'b0; cpu_we = 1'b0; cpu_wa = '0; cpu_wd = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0;
    fill_color = '0; fill_abort = 1'b0;
    tick(); tick();
    chk("rst_we", fb_we, 1'b0);
    chk("rst_wa", fb_wa, 13'h0);
    chk("rst_wd", fb_wd, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
`ifdef VGA_FB_SEQ_AUTOCLEAR_EN
    run_clear();
`else
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_we", fb_we, 1'b0);
`endif

    // CPU write
    cpu_we = 1'b1; cpu_wa = 13'h0285; cpu_wd = 8'hE0;
    tick();
    cpu_we = 1'b0;
    chk("cpu_we", fb_we, 1'b1);
    chk("cpu_wa", fb_wa, 13'h0285);
    chk("cpu_wd", fb_wd, 8'hE0);
    tick();
    chk("cpu_hold_we", fb_we, 1'b0);
    chk("cpu_hold_wa", fb_wa, 13'h0285);

    // Fill 2x2
    start_fill(7'd3, 7'd4, 6'd1, 6'd2, 8'h1C);
    tick();                                  // N+1
    fill_start = 1'b0;
    chk("f_busy_n1", busy, 1'b1);
    chk("f_we_n1", fb_we, 1'b0);
    tick();
    chk("f_wa_n2", fb_wa, 13'h0083); chk("f_we_n2", fb_we, 1'b1); chk("f_wd_n2", fb_wd, 8'h1C);
    tick();
    chk("f_wa_n3", fb_wa, 13'h0084); chk("f_done_n3", done, 1'b0);
    tick();
    chk("f_wa_n4", fb_wa, 13'h0103);
    tick();
    chk("f_wa_n5", fb_wa, 13'h0104); chk("f_we_n5", fb_we, 1'b1);
    chk("f_done_n5", done, 1'b1); chk("f_busy_n5", busy, 1'b0);
    tick();
    chk("f_we_n6", fb_we, 1'b0); chk("f_done_n6", done, 1'b0);
    chk("f_restore_n6", fb_wa, 13'h0285);

    // Contention: CPU strobe in N+2 lands at N+3
    start_fill(7'd3, 7'd4, 6'd1, 6'd2, 8'h1C);
    tick();
    fill_start = 1'b0;
    tick();                                  // N+2
    chk("c_wa_n2", fb_wa, 13'h0083);
    cpu_we = 1'b1; cpu_wa = 13'h0000; cpu_wd = 8'hFF;
    tick();                                  // N+3
    cpu_we = 1'b0;
    chk("c_we_n3", fb_we, 1'b1); chk("c_wa_n3", fb_wa, 13'h0000); chk("c_wd_n3", fb_wd, 8'hFF);
    tick();
    chk("c_wa_n4", fb_wa, 13'h0084); chk("c_wd_n4", fb_wd, 8'h1C);
    tick();
    chk("c_wa_n5", fb_wa, 13'h0103); chk("c_done_n5", done, 1'b0);
    tick();
    chk("c_wa_n6", fb_wa, 13'h0104); chk("c_done_n6", done, 1'b1);
    tick();
    chk("c_restore_n7", fb_wa, 13'h0000); chk("c_we_n7", fb_we, 1'b0);

    // Invalid requests
    start_fill(7'd10, 7'd5, 6'd0, 6'd0, 8'h11);
    tick();
    fill_start = 1'b0;
    chk("e_x_err", err, 1'b1); chk("e_x_busy", busy, 1'b0); chk("e_x_we", fb_we, 1'b0);
    tick();
    chk("e_x_err_clr", err, 1'b0); chk("e_x_we2", fb_we, 1'b0);
    start_fill(7'd0, 7'd80, 6'd0, 6'd0, 8'h11);
    tick();
    fill_start = 1'b0;
    chk("e_x80_err", err, 1'b1); chk("e_x80_busy", busy, 1'b0);
    start_fill(7'd79, 7'd79, 6'd0, 6'd60, 8'h11);
    tick();
    fill_start = 1'b0;
    chk("e_y60_err", err, 1'b1);
    tick();
    chk("e_y60_busy", busy, 1'b0); chk("e_y60_we", fb_we, 1'b0);

    // Abort in IDLE is ignored
    fill_abort = 1'b1;
    tick();
    fill_abort = 1'b0;
    chk("a_idle_done", done, 1'b0);

    // 10x10 fill, ignored restart, then abort
    start_fill(7'd10, 7'd19, 6'd5, 6'd14, 8'h55);
    tick();                                  // N+1
    fill_start = 1'b0;
    tick();                                  // N+2
    chk("a_wa_n2", fb_wa, 13'h028A);
    start_fill(7'd0, 7'd0, 6'd0, 6'd0, 8'hAA);
    tick();                                  // N+3
    fill_start = 1'b0;
    chk("a_wa_n3", fb_wa, 13'h028B); chk("a_wd_n3", fb_wd, 8'h55); chk("a_err_n3", err, 1'b0);
    tick();                                  // N+4
    chk("a_wa_n4", fb_wa, 13'h028C);
    fill_abort = 1'b1;
    tick();                                  // N+5
    fill_abort = 1'b0;
    chk("a_done", done, 1'b1); chk("a_we", fb_we, 1'b0); chk("a_busy", busy, 1'b0);
    cnt_we = 0; cnt_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fb_we) cnt_we++;
      if (done) cnt_done++;
    end
    chk("a_after_we", cnt_we, 0);
    chk("a_after_done", cnt_done, 0);

    // Back-to-back 1x1 fills
    start_fill(7'd5, 7'd5, 6'd5, 6'd5, 8'h03);
    tick();
    fill_start = 1'b0;
    tick();                                  // N+2
    chk("b1_wa", fb_wa, 13'h0285); chk("b1_done", done, 1'b1);
    tick();                                  // first IDLE cycle after DONE
    start_fill(7'd6, 7'd6, 6'd5, 6'd5, 8'h07);
    tick();
    fill_start = 1'b0;
    chk("b2_busy", busy, 1'b1);
    tick();
    chk("b2_wa", fb_wa, 13'h0286); chk("b2_wd", fb_wd, 8'h07); chk("b2_done", done, 1'b1);
    tick();

    // Reset mid-fill
    start_fill(7'd10, 7'd19, 6'd5, 6'd14, 8'h66);
    tick();
    fill_start = 1'b0;
    tick(); tick();
    chk("r_we_pre", fb_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r_we", fb_we, 1'b0); chk("r_wa", fb_wa, 13'h0); chk("r_wd", fb_wd, 8'h0);
    chk("r_busy", busy, 1'b0); chk("r_done", done, 1'b0); chk("r_err", err, 1'b0);
    tick();
    rst_n = 1'b1;
`ifdef VGA_FB_SEQ_AUTOCLEAR_EN
    run_clear();
`else
    cnt_we = 0; cnt_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fb_we) cnt_we++;
      if (done) cnt_done++;
    end
    chk("r_post_we", cnt_we, 0);
    chk("r_post_done", cnt_done, 0);
    chk("r_post_busy", busy, 1'b0);
    chk("r_post_wa", fb_wa, 13'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
